// File: rtl/stn_frc_sequencer_if.sv
// Pixel, dither-engine and panel-side signals of the STN FRC sequencer.
interface stn_frc_sequencer_if #(
  parameter int BUS_W = 8
);
  logic             en;
  logic             pix_valid;
  logic [4:0]       pix_data;
  logic             pix_ready;
  logic [4:0]       dith_raw;
  logic             dith_inv;
  logic             dith_bit;
  logic             dith_adv;
  logic [BUS_W-1:0] lcd_d;
  logic             lcd_cp;
  logic             lcd_lp;
  logic             lcd_flm;
  logic             lcd_m;
  logic             busy;

  modport master (
    input  en, pix_valid, pix_data, dith_bit,
    output pix_ready, dith_raw, dith_inv, dith_adv,
           lcd_d, lcd_cp, lcd_lp, lcd_flm, lcd_m, busy
  );

  modport slave (
    output en, pix_valid, pix_data, dith_bit,
    input  pix_ready, dith_raw, dith_inv, dith_adv,
           lcd_d, lcd_cp, lcd_lp, lcd_flm, lcd_m, busy
  );
endinterface

// File: rtl/stn_frc_sequencer.sv
// STN FRC sequencer: feeds gray pixels to the dither engine, packs the
// returned bits into panel words and generates CP/LP/FLM/M timing.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   S_IDLE   | stopped; waits for en at a frame boundary
//   S_ACTIVE | accepting pixels of line y, packing dither bits
//   S_LATCH  | one cycle after the last pixel; final CP of the line
//   S_BLANK  | HBLANK cycles starting with the LP cycle
module stn_frc_sequencer #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter int BUS_W    = 8,
  parameter int HBLANK   = 8,
  parameter int M_LINES  = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  stn_frc_sequencer_if.master bus
);

  localparam int XW   = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int YW   = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int BCW  = (BUS_W > 1) ? $clog2(BUS_W) : 1;
  localparam int HBW  = (HBLANK > 1) ? $clog2(HBLANK) : 1;
  localparam int MW   = (M_LINES > 0) ? $clog2(M_LINES + 1) : 1;
  localparam int M_TC = (M_LINES > 0) ? M_LINES - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_LATCH, S_BLANK} state_t;

  state_t           state_q, state_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [BCW-1:0]   bit_q, bit_d;
  logic [HBW-1:0]   hb_q, hb_d;
  logic [MW-1:0]    mc_q, mc_d;
  logic [BUS_W-1:0] sr_q, sr_d;
  logic [BUS_W-1:0] lcd_d_q, lcd_d_d;
  logic             cp_q, cp_d;
  logic             lp_q, lp_d;
  logic             flm_q, flm_d;
  logic             adv_q, adv_d;
  logic             m_q, m_d;
  logic             last_line;

  assign last_line = (y_q == YW'(V_LINES - 1));

  // State register and all counters / strobes; async clear drops any pulse at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      bit_q   <= '0;
      hb_q    <= '0;
      mc_q    <= '0;
      sr_q    <= '0;
      lcd_d_q <= '0;
      cp_q    <= 1'b0;
      lp_q    <= 1'b0;
      flm_q   <= 1'b0;
      adv_q   <= 1'b0;
      m_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      bit_q   <= bit_d;
      hb_q    <= hb_d;
      mc_q    <= mc_d;
      sr_q    <= sr_d;
      lcd_d_q <= lcd_d_d;
      cp_q    <= cp_d;
      lp_q    <= lp_d;
      flm_q   <= flm_d;
      adv_q   <= adv_d;
      m_q     <= m_d;
    end
  end

  // Next-state, pixel packing and panel strobe generation.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    bit_d   = bit_q;
    hb_d    = hb_q;
    mc_d    = mc_q;
    sr_d    = sr_q;
    lcd_d_d = lcd_d_q;
    m_d     = m_q;
    cp_d    = 1'b0;
    lp_d    = 1'b0;
    flm_d   = 1'b0;
    adv_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.en) begin
          state_d = S_ACTIVE;
          x_d     = '0;
          y_d     = '0;
          bit_d   = BCW'(BUS_W - 1);
        end
      end
      S_ACTIVE: begin
        if (bus.pix_valid) begin
          sr_d = BUS_W'({sr_q, bus.dith_bit});
          x_d  = x_q + 1'b1;
          // bit_q is a down-counter of pixels left in the current word
          if (bit_q == '0) begin
            bit_d   = BCW'(BUS_W - 1);
            lcd_d_d = sr_d;
            cp_d    = 1'b1;
          end else begin
            bit_d = bit_q - 1'b1;
          end
          if (x_q == XW'(H_PIXELS - 1)) begin
            state_d = S_LATCH;
            x_d     = '0;
          end
        end
      end
      S_LATCH: begin
        state_d = S_BLANK;
        lp_d    = 1'b1;
        flm_d   = (y_q == '0);
        hb_d    = HBW'(HBLANK - 1);
      end
      S_BLANK: begin
        if (hb_q == '0) begin
          x_d   = '0;
          bit_d = BCW'(BUS_W - 1);
          if (last_line) begin
            y_d     = '0;
            state_d = bus.en ? S_ACTIVE : S_IDLE;
          end else begin
            y_d     = y_q + 1'b1;
            state_d = S_ACTIVE;
          end
        end else begin
          hb_d = hb_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // frame advance lands on the final blank cycle of the last line
    adv_d = (state_d == S_BLANK) && (hb_d == '0) && last_line;

    // M flips in the same cycle as the LP (or advance) that triggers it
    if (M_LINES > 0) begin
      if (lp_d) begin
        if (mc_q == MW'(M_TC)) begin
          mc_d = '0;
          m_d  = ~m_q;
        end else begin
          mc_d = mc_q + 1'b1;
        end
      end
    end else if (adv_d) begin
      m_d = ~m_q;
    end
  end

  assign bus.pix_ready = (state_q == S_ACTIVE);
  assign bus.dith_raw  = (state_q == S_ACTIVE) ? bus.pix_data : 5'd0;
  assign bus.dith_inv  = (state_q == S_ACTIVE) & (x_q[0] ^ y_q[0]);
  assign bus.dith_adv  = adv_q;
  assign bus.lcd_d     = lcd_d_q;
  assign bus.lcd_cp    = cp_q;
  assign bus.lcd_lp    = lp_q;
  assign bus.lcd_flm   = flm_q;
  assign bus.lcd_m     = m_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_stn_frc_sequencer.sv
// Directed bench for stn_frc_sequencer with a stub dither engine
// (dith_bit = dith_raw[0] ^ dith_inv).
module tb_stn_frc_sequencer;
  localparam int H  = 16;
  localparam int V  = 4;
  localparam int BW = 4;
  localparam int HB = 2;
  localparam int ML = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int   n_cmp   = 0;
  int   n_err   = 0;
  int   lp_seen = 0;
  logic exp_m   = 1'b0;

  int   n_cp = 0, n_lp = 0, n_flm = 0, n_adv = 0;
  int   s_cp, s_lp, s_flm, s_adv;
  int   n2_adv = 0, n2_mtog = 0, n2_coinc = 0;
  int   s2_adv, s2_mtog, s2_coinc;
  logic m2_prev = 1'b0;
  int   cnt;

  stn_frc_sequencer_if #(.BUS_W(BW)) b  ();
  stn_frc_sequencer_if #(.BUS_W(BW)) b2 ();

  assign b.dith_bit  = b.dith_raw[0] ^ b.dith_inv;
  assign b2.dith_bit = b2.dith_raw[0] ^ b2.dith_inv;

  stn_frc_sequencer #(
    .H_PIXELS(H), .V_LINES(V), .BUS_W(BW), .HBLANK(HB), .M_LINES(ML)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(b.master)
  );

  stn_frc_sequencer #(
    .H_PIXELS(H), .V_LINES(V), .BUS_W(BW), .HBLANK(HB), .M_LINES(0)
  ) u_dut_m0 (
    .clk(clk), .rst_n(rst_n), .bus(b2.master)
  );

  always #5 clk = ~clk;

  // Pulse tallies, sampled on the rising edge (values of the cycle just ended).
  always @(posedge clk) begin
    m2_prev <= b2.lcd_m;
    if (rst_n) begin
      n_cp  <= n_cp  + int'(b.lcd_cp);
      n_lp  <= n_lp  + int'(b.lcd_lp);
      n_flm <= n_flm + int'(b.lcd_flm);
      n_adv <= n_adv + int'(b.dith_adv);
      n2_adv <= n2_adv + int'(b2.dith_adv);
      if (b2.lcd_m != m2_prev) begin
        n2_mtog  <= n2_mtog + 1;
        n2_coinc <= n2_coinc + int'(b2.dith_adv);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic snap();
    s_cp  = n_cp;
    s_lp  = n_lp;
    s_flm = n_flm;
    s_adv = n_adv;
  endtask

  function automatic logic [4:0] pix(input int y, input int x, input int mode);
    int v;
    if (mode == 0) v = x;
    else           v = x * x + (x >> 2) * 3 + (x >> 1) + y;
    return 5'(v & 31);
  endfunction

  function automatic logic [3:0] word_exp(input int y, input int w, input int mode);
    logic [3:0] r;
    logic [4:0] p;
    int         x;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      x = 4 * w + i;
      p = pix(y, x, mode);
      r[3-i] = p[0] ^ ((x % 2) == 1) ^ ((y % 2) == 1);
    end
    return r;
  endfunction

  task automatic feed_line(input int y, input int mode, input int gapmax,
                           input int drop_x, input int nx);
    int g;
    for (int x = 0; x < nx; x++) begin
      g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
      for (int k = 0; k < g; k++) begin
        b.pix_valid = 1'b0;
        b.pix_data  = 5'd31;
        #1;
        chk("stall_ready", b.pix_ready, 1);
        tick();
        chk("stall_cp", b.lcd_cp, 0);
      end
      if (x == drop_x) b.en = 1'b0;
      b.pix_valid = 1'b1;
      b.pix_data  = pix(y, x, mode);
      #1;
      chk("ready", b.pix_ready, 1);
      chk("dith_raw", b.dith_raw, pix(y, x, mode));
      chk("dith_inv", b.dith_inv, (x ^ y) & 1);
      tick();
      if (x % 4 == 3) begin
        chk("cp_word", b.lcd_cp, 1);
        chk("lcd_d", b.lcd_d, word_exp(y, x / 4, mode));
      end else begin
        chk("cp_idle", b.lcd_cp, 0);
      end
    end
  endtask

  task automatic line_tail(input int y, input bit next_active);
    b.pix_valid = 1'b1;
    chk("latch_ready", b.pix_ready, 0);
    chk("latch_lp", b.lcd_lp, 0);
    tick();
    lp_seen++;
    if (lp_seen % ML == 0) exp_m = ~exp_m;
    chk("lp", b.lcd_lp, 1);
    chk("flm", b.lcd_flm, (y == 0) ? 1 : 0);
    chk("lp_cp", b.lcd_cp, 0);
    chk("blank_ready", b.pix_ready, 0);
    chk("lcd_m", b.lcd_m, exp_m);
    chk("adv_early", b.dith_adv, 0);
    tick();
    chk("lp_end", b.lcd_lp, 0);
    chk("adv", b.dith_adv, (y == V - 1) ? 1 : 0);
    chk("blank2_ready", b.pix_ready, 0);
    tick();
    chk("next_ready", b.pix_ready, next_active);
    chk("next_busy", b.busy, next_active);
  endtask

  task automatic feed_frame(input int mode, input int gapmax, input int drop_line);
    for (int y = 0; y < V; y++) begin
      feed_line(y, mode, gapmax, (y == drop_line) ? 8 : -1, H);
      line_tail(y, !((y == V - 1) && (b.en == 1'b0)));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, b.busy, 0);
    chk({tag, "_ready"}, b.pix_ready, 0);
    chk({tag, "_cp"}, b.lcd_cp, 0);
    chk({tag, "_lp"}, b.lcd_lp, 0);
    chk({tag, "_flm"}, b.lcd_flm, 0);
    chk({tag, "_m"}, b.lcd_m, 0);
    chk({tag, "_d"}, b.lcd_d, 0);
    chk({tag, "_adv"}, b.dith_adv, 0);
    chk({tag, "_raw"}, b.dith_raw, 0);
    chk({tag, "_inv"}, b.dith_inv, 0);
  endtask

  initial begin
    b.en = 1'b0;  b.pix_valid = 1'b0;  b.pix_data = 5'd0;
    b2.en = 1'b0; b2.pix_valid = 1'b0; b2.pix_data = 5'd0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    b.pix_valid = 1'b1;
    b.pix_data  = 5'd9;
    tick();
    tick();
    chk("idle_busy", b.busy, 0);
    chk("idle_ready", b.pix_ready, 0);

    // scenario 1: line 0 of frame A with pixels 0..15
    b.en = 1'b1;
    tick();
    chk("start_ready", b.pix_ready, 1);
    snap();
    feed_line(0, 0, 0, -1, H);
    line_tail(0, 1'b1);
    chk("s1_cp", n_cp - s_cp, 4);
    chk("s1_lp", n_lp - s_lp, 1);
    chk("s1_flm", n_flm - s_flm, 1);
    for (int y = 1; y < V; y++) begin
      feed_line(y, 0, 0, -1, H);
      line_tail(y, 1'b1);
    end

    // scenario 2: full frame with varied data
    snap();
    feed_frame(1, 0, -1);
    chk("s2_cp", n_cp - s_cp, 16);
    chk("s2_lp", n_lp - s_lp, 4);
    chk("s2_flm", n_flm - s_flm, 1);
    chk("s2_adv", n_adv - s_adv, 1);

    // scenario 3: random pix_valid gaps
    snap();
    feed_frame(0, 5, -1);
    chk("s3_cp", n_cp - s_cp, 16);
    chk("s3_lp", n_lp - s_lp, 4);
    chk("s3_adv", n_adv - s_adv, 1);

    // scenario 4: en dropped during line 1
    snap();
    feed_frame(1, 0, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("s4_idle_ready", b.pix_ready, 0);
      chk("s4_idle_busy", b.busy, 0);
    end
    chk("s4_lp", n_lp - s_lp, 4);
    chk("s4_adv", n_adv - s_adv, 1);

    // scenario 5: async reset in the middle of line 2
    b.en = 1'b1;
    tick();
    chk("s5_ready", b.pix_ready, 1);
    feed_line(0, 1, 0, -1, H);
    line_tail(0, 1'b1);
    feed_line(1, 1, 0, -1, H);
    line_tail(1, 1'b1);
    feed_line(2, 1, 0, -1, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("s5_rst");
    #2;
    rst_n   = 1'b1;
    lp_seen = 0;
    exp_m   = 1'b0;
    tick();
    chk("s5_restart_ready", b.pix_ready, 1);
    feed_line(0, 1, 0, -1, H);
    line_tail(0, 1'b1);
    b.pix_valid = 1'b0;
    b.en        = 1'b0;

    // scenario 6: M_LINES=0, three frames
    s2_adv   = n2_adv;
    s2_mtog  = n2_mtog;
    s2_coinc = n2_coinc;
    b2.pix_valid = 1'b1;
    b2.pix_data  = 5'd7;
    b2.en        = 1'b1;
    cnt = 0;
    while ((n2_adv - s2_adv) < 2 && cnt < 1000) begin
      tick();
      cnt++;
    end
    chk("s6_two_frames_in_time", (cnt < 1000) ? 1 : 0, 1);
    b2.en = 1'b0;
    cnt = 0;
    while (b2.busy && cnt < 1000) begin
      tick();
      cnt++;
    end
    chk("s6_idle_in_time", (cnt < 1000) ? 1 : 0, 1);
    tick();
    tick();
    chk("s6_busy", b2.busy, 0);
    chk("s6_adv", n2_adv - s2_adv, 3);
    chk("s6_mtog", n2_mtog - s2_mtog, 3);
    chk("s6_coinc", n2_coinc - s2_coinc, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
